bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter RAM_BASE, default 32'h0001_0000, SHALL set the data-RAM window base.
REQ-002 Parameter RAM_SIZE, default 32'h0000_4000, SHALL set the data-RAM window size in bytes.
REQ-003 Parameter IO_BASE, default 32'h0002_0000, SHALL set the USB FIFO window base; the window is 4 bytes.
REQ-004 clk_i  in  1  clock.
REQ-005 rstn_i  in  1  reset; asynchronous, active-low.
REQ-006 mN_req_i  in  1  access request from master N (N=0 CPU data port, N=1 USB loader).
REQ-007 mN_we_i  in  1  write when 1, read when 0.
REQ-008 mN_addr_i  in  32  byte address.
REQ-009 mN_wdata_i  in  32  write data.
REQ-010 mN_acc_i  in  2  access size (byte/half/word).
REQ-011 mN_sext_i  in  1  read sign-extend.
REQ-012 mN_gnt_o  out  1  one-cycle request-accepted pulse.
REQ-013 mN_done_o  out  1  one-cycle completion pulse.
REQ-014 mN_rdata_o  out  32  read data, valid with mN_done_o.
REQ-015 ram_r_en_o, ram_wr_en_o  out  1 each  data-RAM strobes.
REQ-016 ram_addr_o, ram_wdata_o  out  32 each; ram_acc_o  out  2; ram_sext_o  out  1  data-RAM request fields.
REQ-017 ram_rdata_i  in  32; ram_wr_ready_i  in  1  data-RAM read data and write completion.
REQ-018 fifo_sel_o, fifo_rd_o, fifo_wr_o  out  1 each; fifo_addr_o  out  2; fifo_wdata_o  out  8  FIFO port.
REQ-019 fifo_rdata_i  in  8  FIFO read data.
REQ-020 err_o  out  1  one-cycle unmapped-address pulse.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, WAIT_WR, RESP.
REQ-022 IDLE: with any mN_req_i high, SHALL pulse the winner's mN_gnt_o, latch its we/addr/wdata/acc/sext, and go to ACCESS next cycle.
REQ-023 A master SHALL hold req and fields stable until gnt; the latched copy alone drives the slaves thereafter.
REQ-024 Decode: RAM if RAM_BASE <= addr < RAM_BASE+RAM_SIZE (32-bit unsigned, no wrap); IO if IO_BASE <= addr < IO_BASE+4; otherwise unmapped.
REQ-025 ACCESS, RAM read: ram_r_en_o=1 for exactly one cycle -> RESP.
REQ-026 ACCESS, RAM write: ram_wr_en_o=1 -> WAIT_WR; ram_wr_en_o held while in WAIT_WR until ram_wr_ready_i=1 -> RESP.
REQ-027 ACCESS, IO: fifo_sel_o=1 plus fifo_rd_o or fifo_wr_o for one cycle; fifo_addr_o=addr[1:0]; fifo_wdata_o=wdata[7:0] -> RESP.
REQ-028 ACCESS, unmapped: no slave strobe; err_o=1 for one cycle -> RESP; read data SHALL be 32'h0.
REQ-029 RESP: pulse the owner's mN_done_o; mN_rdata_o = ram_rdata_i (RAM), zero-extended fifo_rdata_i (IO), or 0 -> IDLE.
REQ-030 Latency: gnt at T, strobe at T+1, done at T+2 for reads, FIFO writes and unmapped; RAM write done one cycle after ram_wr_ready_i is seen.
REQ-031 All slave outputs and mN_rdata_o SHALL be 0 whenever not actively selected, since the downstream read bus is OR-combined.
REQ-032 New requests arriving outside IDLE SHALL wait; back-to-back grants SHALL be at least 3 cycles apart.

Reset
REQ-033 Reset SHALL force IDLE, all outputs 0, and the arbitration pointer to "m1 last served"; reset mid-transaction SHALL abort it without a done pulse.

Configuration
REQ-034 With BUS_ARB_RR_EN defined, simultaneous requests SHALL be granted to the master not served last (round-robin).
REQ-035 Without BUS_ARB_RR_EN, m0 SHALL always win simultaneous requests (fixed priority); the pointer is absent.

Verification
REQ-036 m0 reads 32'h0001_0010 with ram_rdata_i=32'hDEAD_BEEF -> gnt at T, ram_r_en_o at T+1, m0_done_o and m0_rdata_o=32'hDEAD_BEEF at T+2.
REQ-037 m1 writes 32'h0001_0004 with ram_wr_ready_i delayed 3 cycles -> ram_wr_en_o high 4 cycles, m1_done_o one cycle after ready.
REQ-038 m0 reads 32'h0002_0001 with fifo_rdata_i=8'h5A -> fifo_sel_o=fifo_rd_o=1, fifo_addr_o=2'd1, m0_rdata_o=32'h0000_005A.
REQ-039 m0 reads 32'h0003_0000 -> no strobes, err_o pulse, m0_done_o with rdata 0.
REQ-040 Both masters request continuously with BUS_ARB_RR_EN defined -> grants m0,m1,m0,m1; without it -> m0 only; reset asserted during WAIT_WR -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - per-master request/response bundle for bus_arbiter
interface bus_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  acc;
    logic        sext;
    logic        gnt;
    logic        done;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, acc, sext,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata, acc, sext,
        output gnt, done, rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master arbiter routing to data RAM, USB FIFO or error
// Optional BUS_ARB_RR_EN selects round-robin arbitration instead of fixed m0 priority.
module bus_arbiter #(
    parameter logic [31:0] RAM_BASE = 32'h0001_0000,
    parameter logic [31:0] RAM_SIZE = 32'h0000_4000,
    parameter logic [31:0] IO_BASE  = 32'h0002_0000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    bus_arbiter_if.slave      m0,
    bus_arbiter_if.slave      m1,
    output logic              ram_r_en_o,
    output logic              ram_wr_en_o,
    output logic [31:0]       ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic [1:0]        ram_acc_o,
    output logic              ram_sext_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic              ram_wr_ready_i,
    output logic              fifo_sel_o,
    output logic              fifo_rd_o,
    output logic              fifo_wr_o,
    output logic [1:0]        fifo_addr_o,
    output logic [7:0]        fifo_wdata_o,
    input  logic [7:0]        fifo_rdata_i,
    output logic              err_o
);
    // 33-bit window ends so a window touching the top of the address space cannot wrap
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE};
    localparam logic [32:0] IO_END  = {1'b0, IO_BASE} + 33'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  acc_q, acc_d;
    logic        sext_q, sext_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        ram_r_en_q, ram_r_en_d;
    logic        ram_wr_en_q, ram_wr_en_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [1:0]  ram_acc_q, ram_acc_d;
    logic        ram_sext_q, ram_sext_d;
    logic        fifo_sel_q, fifo_sel_d;
    logic        fifo_rd_q, fifo_rd_d;
    logic        fifo_wr_q, fifo_wr_d;
    logic [1:0]  fifo_addr_q, fifo_addr_d;
    logic [7:0]  fifo_wdata_q, fifo_wdata_d;
    logic        err_q, err_d;

    logic        hit_ram;
    logic        hit_io;
    logic        pick1;
    logic [31:0] resp_data;

`ifdef BUS_ARB_RR_EN
    logic        last_q, last_d;

    // last_q = 1 means m1 was served most recently, so m0 wins a tie
    assign pick1 = m1.req && (!m0.req || !last_q);
`else
    assign pick1 = m1.req && !m0.req;
`endif

    assign hit_ram = (addr_q >= RAM_BASE) && ({1'b0, addr_q} < RAM_END);
    assign hit_io  = (addr_q >= IO_BASE)  && ({1'b0, addr_q} < IO_END);

    // Read data is taken from whichever slave was strobed; unmapped returns zero
    assign resp_data = ram_r_en_q ? ram_rdata_i :
                       fifo_rd_q  ? {24'h0, fifo_rdata_i} : 32'h0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        sext_d       = sext_q;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        rdata0_d     = 32'h0;
        rdata1_d     = 32'h0;
        ram_r_en_d   = 1'b0;
        ram_wr_en_d  = 1'b0;
        ram_addr_d   = 32'h0;
        ram_wdata_d  = 32'h0;
        ram_acc_d    = 2'b00;
        ram_sext_d   = 1'b0;
        fifo_sel_d   = 1'b0;
        fifo_rd_d    = 1'b0;
        fifo_wr_d    = 1'b0;
        fifo_addr_d  = 2'b00;
        fifo_wdata_d = 8'h0;
        err_d        = 1'b0;
`ifdef BUS_ARB_RR_EN
        last_d       = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (gnt_q != 2'b00) begin
                    // Grant cycle is over: launch the latched access
                    state_d = ACCESS;
                    if (hit_ram) begin
                        ram_r_en_d  = !we_q;
                        ram_wr_en_d = we_q;
                        ram_addr_d  = addr_q;
                        ram_wdata_d = wdata_q;
                        ram_acc_d   = acc_q;
                        ram_sext_d  = sext_q;
                    end else if (hit_io) begin
                        fifo_sel_d   = 1'b1;
                        fifo_rd_d    = !we_q;
                        fifo_wr_d    = we_q;
                        fifo_addr_d  = addr_q[1:0];
                        fifo_wdata_d = wdata_q[7:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (m0.req || m1.req) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    owner_d = pick1;
                    we_d    = pick1 ? m1.we    : m0.we;
                    addr_d  = pick1 ? m1.addr  : m0.addr;
                    wdata_d = pick1 ? m1.wdata : m0.wdata;
                    acc_d   = pick1 ? m1.acc   : m0.acc;
                    sext_d  = pick1 ? m1.sext  : m0.sext;
`ifdef BUS_ARB_RR_EN
                    last_d  = pick1;
`endif
                end
            end
            ACCESS, WAIT_WR: begin
                if (ram_wr_en_q && !ram_wr_ready_i) begin
                    state_d     = WAIT_WR;
                    ram_wr_en_d = 1'b1;
                    ram_addr_d  = ram_addr_q;
                    ram_wdata_d = ram_wdata_q;
                    ram_acc_d   = ram_acc_q;
                    ram_sext_d  = ram_sext_q;
                end else begin
                    state_d         = RESP;
                    done_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        rdata1_d = resp_data;
                    end else begin
                        rdata0_d = resp_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            acc_q        <= 2'b00;
            sext_q       <= 1'b0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            rdata0_q     <= 32'h0;
            rdata1_q     <= 32'h0;
            ram_r_en_q   <= 1'b0;
            ram_wr_en_q  <= 1'b0;
            ram_addr_q   <= 32'h0;
            ram_wdata_q  <= 32'h0;
            ram_acc_q    <= 2'b00;
            ram_sext_q   <= 1'b0;
            fifo_sel_q   <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_addr_q  <= 2'b00;
            fifo_wdata_q <= 8'h0;
            err_q        <= 1'b0;
`ifdef BUS_ARB_RR_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            acc_q        <= acc_d;
            sext_q       <= sext_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ram_r_en_q   <= ram_r_en_d;
            ram_wr_en_q  <= ram_wr_en_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_acc_q    <= ram_acc_d;
            ram_sext_q   <= ram_sext_d;
            fifo_sel_q   <= fifo_sel_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_wdata_q <= fifo_wdata_d;
            err_q        <= err_d;
`ifdef BUS_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    assign m0.gnt       = gnt_q[0];
    assign m1.gnt       = gnt_q[1];
    assign m0.done      = done_q[0];
    assign m1.done      = done_q[1];
    assign m0.rdata     = rdata0_q;
    assign m1.rdata     = rdata1_q;
    assign ram_r_en_o   = ram_r_en_q;
    assign ram_wr_en_o  = ram_wr_en_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign ram_acc_o    = ram_acc_q;
    assign ram_sext_o   = ram_sext_q;
    assign fifo_sel_o   = fifo_sel_q;
    assign fifo_rd_o    = fifo_rd_q;
    assign fifo_wr_o    = fifo_wr_q;
    assign fifo_addr_o  = fifo_addr_q;
    assign fifo_wdata_o = fifo_wdata_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ram_r_en, ram_wr_en, ram_sext, ram_wr_ready;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0]  ram_acc;
    logic        fifo_sel, fifo_rd, fifo_wr, err;
    logic [1:0]  fifo_addr;
    logic [7:0]  fifo_wdata, fifo_rdata;

    always #5 clk = ~clk;

    bus_arbiter_if m0_if ();
    bus_arbiter_if m1_if ();

    bus_arbiter dut (
        .clk_i(clk), .rstn_i(rstn), .m0(m0_if), .m1(m1_if),
        .ram_r_en_o(ram_r_en), .ram_wr_en_o(ram_wr_en), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_acc_o(ram_acc), .ram_sext_o(ram_sext),
        .ram_rdata_i(ram_rdata), .ram_wr_ready_i(ram_wr_ready),
        .fifo_sel_o(fifo_sel), .fifo_rd_o(fifo_rd), .fifo_wr_o(fifo_wr),
        .fifo_addr_o(fifo_addr), .fifo_wdata_o(fifo_wdata), .fifo_rdata_i(fifo_rdata),
        .err_o(err)
    );

    typedef struct {
        int          m;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   push_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [199:0] all_outs();
        return {m0_if.gnt, m1_if.gnt, m0_if.done, m1_if.done, m0_if.rdata, m1_if.rdata,
                ram_r_en, ram_wr_en, ram_addr, ram_wdata, ram_acc, ram_sext,
                fifo_sel, fifo_rd, fifo_wr, fifo_addr, fifo_wdata, err};
    endfunction

    task automatic set_req(input int m, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_if.req = r; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
            m0_if.acc = 2'd2; m0_if.sext = !we;
        end else begin
            m1_if.req = r; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
            m1_if.acc = 2'd2; m1_if.sext = !we;
        end
    endtask

    task automatic push(input int m, input logic [31:0] rd, input int c);
        exp_t e;
        e.m = m; e.rdata = rd; e.cyc = c;
        sb.push_back(e);
        push_cnt++;
    endtask

    task automatic do_req(input int m, input bit we, input logic [31:0] a, input logic [31:0] d, output int tg);
        set_req(m, 1'b1, we, a, d);
        tg = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_if.gnt) || (m == 1 && m1_if.gnt)) begin
                tg = cyc;
                break;
            end
        end
        chk("gnt_seen", 64'(tg >= 0), 64'd1);
        set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // kind: 0 = RAM, 1 = FIFO, 2 = unmapped
    task automatic check_strobe(input string tag, input int kind, input bit we, input logic [31:0] a, input logic [31:0] d);
        logic [5:0] exp_s;
        exp_s = (kind == 0) ? {!we, we, 4'b0000} :
                (kind == 1) ? {2'b00, 1'b1, !we, we, 1'b0} : 6'b000001;
        chk({tag, "_strobes"}, {ram_r_en, ram_wr_en, fifo_sel, fifo_rd, fifo_wr, err}, exp_s);
        chk({tag, "_ram_fields"}, {ram_addr, ram_wdata, ram_acc, ram_sext},
            (kind == 0) ? {a, d, 2'd2, !we} : 67'h0);
        chk({tag, "_fifo_fields"}, {fifo_addr, fifo_wdata},
            (kind == 1) ? {a[1:0], d[7:0]} : 10'h0);
    endtask

    // Scoreboard monitor: every completion is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        int   m;
        if (m0_if.done || m1_if.done) begin
            done_cnt++;
            chk("single_done", 64'(m0_if.done & m1_if.done), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", {m0_if.done, m1_if.done}, 2'b00);
            end else begin
                e = sb.pop_front();
                m = m1_if.done ? 1 : 0;
                chk("done_master", 64'(m), 64'(e.m));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("done_rdata", (m == 0) ? m0_if.rdata : m1_if.rdata, e.rdata);
                chk("other_rdata", (m == 0) ? m1_if.rdata : m0_if.rdata, 32'h0);
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("done_missing", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end
    end

    logic [31:0] tbl_addr [10] = '{32'h0001_0010, 32'h0003_0000, 32'h0002_0001, 32'h0001_0000,
                                   32'h0001_3FFF, 32'h0001_4000, 32'h0000_FFFF, 32'h0002_0004,
                                   32'h0002_0003, 32'hFFFF_FFFF};
    int          tbl_kind [10] = '{0, 2, 1, 0, 0, 2, 2, 2, 1, 2};

    initial begin
        int          tg, prev, who;
        int          exp_who [4];
        logic [31:0] exp_rd;

        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        ram_rdata = 32'hDEAD_BEEF;
        fifo_rdata = 8'h5A;
        ram_wr_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(all_outs() != '0), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Reads across RAM, FIFO and unmapped windows including edges
        for (int i = 0; i < 10; i++) begin
            exp_rd = (tbl_kind[i] == 0) ? 32'hDEAD_BEEF : (tbl_kind[i] == 1) ? 32'h0000_005A : 32'h0;
            do_req(i % 2, 1'b0, tbl_addr[i], 32'h0, tg);
            push(i % 2, exp_rd, tg + 2);
            @(negedge clk);
            check_strobe($sformatf("rd%0d", i), tbl_kind[i], 1'b0, tbl_addr[i], 32'h0);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("rd%0d_quiet", i), 64'(all_outs() != '0), 64'd0);
        end

        // FIFO write
        do_req(1, 1'b1, 32'h0002_0003, 32'h1234_5678, tg);
        push(1, 32'h0, tg + 2);
        @(negedge clk);
        check_strobe("fifo_wr", 1, 1'b1, 32'h0002_0003, 32'h1234_5678);
        repeat (2) @(negedge clk);

        // RAM write with ready arriving three cycles after the first strobe
        do_req(1, 1'b1, 32'h0001_0004, 32'hCAFE_F00D, tg);
        push(1, 32'h0, tg + 5);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) check_strobe("ram_wr", 0, 1'b1, 32'h0001_0004, 32'hCAFE_F00D);
            chk($sformatf("wr_en_hold%0d", k), {ram_wr_en, ram_addr}, {1'b1, 32'h0001_0004});
            if (k == 4) ram_wr_ready = 1'b1;
        end
        @(negedge clk);
        ram_wr_ready = 1'b0;
        chk("wr_en_drop", 64'(ram_wr_en), 64'd0);
        repeat (2) @(negedge clk);

        // Reset while a write waits for ready: abort with no completion
        do_req(1, 1'b1, 32'h0001_0008, 32'h0BAD_0BAD, tg);
        repeat (2) @(negedge clk);
        chk("wait_wr_active", 64'(ram_wr_en), 64'd1);
        rstn = 1'b0;
        #1;
        chk("abort_outputs", 64'(all_outs() != '0), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Both masters request continuously
`ifdef BUS_ARB_RR_EN
        exp_who = '{0, 1, 0, 1};
`else
        exp_who = '{0, 0, 0, 0};
`endif
        set_req(0, 1'b1, 1'b0, 32'h0001_0020, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0001_0030, 32'h0);
        prev = -100;
        for (int g = 0; g < 4; g++) begin
            tg = -1;
            who = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m0_if.gnt || m1_if.gnt) begin
                    tg = cyc;
                    who = m1_if.gnt ? 1 : 0;
                    break;
                end
            end
            chk($sformatf("arb%0d_winner", g), 64'(who), 64'(exp_who[g]));
            chk($sformatf("arb%0d_single_gnt", g), 64'(m0_if.gnt & m1_if.gnt), 64'd0);
            if (g > 0) chk($sformatf("arb%0d_spacing", g), 64'(tg - prev >= 3), 64'd1);
            if (who >= 0) push(who, 32'hDEAD_BEEF, tg + 2);
            prev = tg;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(push_cnt));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
